// File: rtl/cpu_defs_pkg.sv
// Shared CPU encoding constants and write-back payload types.
package cpu_defs;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RAW  = 5;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LB     = 6'h20;
   localparam logic [5:0] OP_LH     = 6'h21;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_LBU    = 6'h24;
   localparam logic [5:0] OP_LHU    = 6'h25;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SH     = 6'h29;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_SLL    = 6'h00;
   localparam logic [5:0] FN_SRL    = 6'h02;
   localparam logic [5:0] FN_SRA    = 6'h03;
   localparam logic [5:0] FN_SLLV   = 6'h04;
   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_JALR   = 6'h09;
   localparam logic [5:0] FN_MOVZ   = 6'h0A;
   localparam logic [5:0] FN_ADDU   = 6'h21;
   localparam logic [5:0] FN_SUBU   = 6'h23;
   localparam logic [5:0] FN_AND    = 6'h24;
   localparam logic [5:0] FN_OR     = 6'h25;
   localparam logic [5:0] FN_SLT    = 6'h2A;

   localparam logic [4:0] RT_BGEZAL = 5'h11;
   localparam logic [4:0] REG_RA    = 5'd31;
   localparam logic [31:0] PC_RESET = 32'h0000_3000;

   typedef enum logic [1:0] {
      WD_ALU  = 2'd0,
      WD_MEM  = 2'd1,
      WD_LINK = 2'd2
   } wd_src_e;

   typedef struct packed {
      logic            we;
      logic [RAW-1:0]  wa;
      logic [XLEN-1:0] wd;
   } wb_wr_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational W-stage decode: destination register, write data and effective enable.
module wb_decode
   import cpu_defs::*;
#(
   parameter logic [31:0] LINK_OFS = 32'd4
) (
   input  logic [31:0] IR_W,
   input  logic [31:0] PC4_W,
   input  logic [31:0] AO_W,
   input  logic [31:0] DR_W,
   input  logic        movz_W,
   input  logic        bge_W,
   output logic        WE,
   output logic [4:0]  WA,
   output logic [31:0] WD
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] link;
   logic        wr_c;
   logic [4:0]  dst_c;
   wd_src_e     src_c;
   logic        unused_ir;

   assign op        = IR_W[31:26];
   assign rt        = IR_W[20:16];
   assign rd        = IR_W[15:11];
   assign funct     = IR_W[5:0];
   assign link      = PC4_W + LINK_OFS;
   assign unused_ir = ^{IR_W[25:21], IR_W[10:6]};

   // Instruction class -> (write?, destination, data source)
   always_comb begin
      wr_c  = 1'b0;
      dst_c = 5'd0;
      src_c = WD_ALU;
      unique case (op)
         OP_RTYPE: begin
            unique case (funct)
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT,
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV: begin
                  wr_c  = 1'b1;
                  dst_c = rd;
               end
               FN_JALR: begin
                  wr_c  = 1'b1;
                  dst_c = rd;
                  src_c = WD_LINK;
               end
               FN_MOVZ: begin
                  wr_c  = movz_W;
                  dst_c = rd;
               end
               default: ;
            endcase
         end
         OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU: begin
            wr_c  = 1'b1;
            dst_c = rt;
         end
         OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
            wr_c  = 1'b1;
            dst_c = rt;
            src_c = WD_MEM;
         end
         OP_JAL: begin
            wr_c  = 1'b1;
            dst_c = REG_RA;
            src_c = WD_LINK;
         end
         OP_REGIMM: begin
            if (rt == RT_BGEZAL) begin
               wr_c  = bge_W;
               dst_c = REG_RA;
               src_c = WD_LINK;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      WD = AO_W;
      unique case (src_c)
         WD_MEM:  WD = DR_W;
         WD_LINK: WD = link;
         default: WD = AO_W;
      endcase
   end

   // $0 writes are squashed here so the hazard unit never sees them
   assign WE = wr_c && (dst_c != 5'd0);
   assign WA = WE ? dst_c : 5'd0;

endmodule

// File: rtl/grf_wb.sv
// Write-back stage plus general register file with W->D bypass.
// Optional GRF_TRACE_EN: prints each committed write in simulation.
module grf_wb
   import cpu_defs::*;
#(
   parameter int unsigned NREG     = 32,
   parameter logic [31:0] LINK_OFS = 32'd4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] IR_W,
   input  logic [31:0] PC4_W,
   input  logic [31:0] AO_W,
   input  logic [31:0] DR_W,
   input  logic        movz_W,
   input  logic        bge_W,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   output logic [31:0] RD1,
   output logic [31:0] RD2,
   output logic        WE_W,
   output logic [4:0]  WA_W,
   output logic [31:0] WD_W
);

   logic [31:0] regs_q [NREG];
   logic [31:0] regs_d [NREG];
   wb_wr_t      wr;

   wb_decode #(
      .LINK_OFS (LINK_OFS)
   ) u_decode (
      .IR_W   (IR_W),
      .PC4_W  (PC4_W),
      .AO_W   (AO_W),
      .DR_W   (DR_W),
      .movz_W (movz_W),
      .bge_W  (bge_W),
      .WE     (wr.we),
      .WA     (wr.wa),
      .WD     (wr.wd)
   );

   assign WE_W = wr.we;
   assign WA_W = wr.wa;
   assign WD_W = wr.wd;

   // Reset wins over a pending write; WE_W already excludes $0
   always_comb begin
      regs_d = regs_q;
      if (Reset) begin
         for (int i = 0; i < NREG; i++) regs_d[i] = '0;
      end else if (wr.we) begin
         regs_d[wr.wa] = wr.wd;
      end
   end

   always_ff @(posedge Clk) begin
      regs_q <= regs_d;
   end

   assign RD1 = (A1 == 5'd0)              ? 32'd0 :
                (wr.we && (A1 == wr.wa))  ? wr.wd : regs_q[A1];
   assign RD2 = (A2 == 5'd0)              ? 32'd0 :
                (wr.we && (A2 == wr.wa))  ? wr.wd : regs_q[A2];

`ifdef GRF_TRACE_EN
   always_ff @(posedge Clk) begin
      if (!Reset && wr.we) begin
         $display("@%h: $%d <= %h", PC4_W - 32'd4, wr.wa, wr.wd);
      end
   end
`endif

endmodule
